// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, start/done handshake (optional ovf via SERIAL_ADDER_OVF_EN)
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] shift_a, shift_b, psum, psum_next;
  logic [CW-1:0]    cnt;
  logic             carry, s0, c0, s, c1, c;
  half_adder ha0 (.a(shift_a[0]), .b(shift_b[0]), .s(s0), .c(c0));
  half_adder ha1 (.a(s0), .b(carry), .s(s), .c(c1));
  assign c = c0 | c1;
  assign psum_next = {s, psum[WIDTH-1:1]};
  // FSM: capture operands on accepted start, shift one bit per cycle, register result at the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift_a <= '0;
      shift_b <= '0;
      psum    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        SHIFT: begin
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          psum    <= psum_next;
          carry   <= c;
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= psum_next;
            cout  <= c;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ c;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            shift_a <= a;
            shift_b <= b;
            carry   <= cin;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder. Computes one bit per clock, LSB first, with a registered carry.
- Per-bit full-adder cell is two half_adder instances plus an OR of their carries. The block is the direct sequential consumer of half_adder sum/carry.
- Start/done handshake toward the controller.
- Result registers hold the last completed sum, so outputs stay stable while the next operation runs.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  carry-in; captured on the accepted start edge.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse when a new result is loaded.
- sum  out  WIDTH  last completed sum (registered).
- cout  out  1  last completed carry-out (registered).

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset, applied at any time including mid-SHIFT:
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry flop and bit counter cleared.
  - Operation in progress is discarded; no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: load shift_a=a, shift_b=b, carry=cin, cnt=0; go to SHIFT; busy=1 from the next cycle.
  - start=0: stay.
- SHIFT, each edge:
  - Bit cell computes s = shift_a[0]^shift_b[0]^carry and c = majority(shift_a[0], shift_b[0], carry), via two half adders + OR.
  - s shifted into partial-sum register at MSB, register shifts right; shift_a and shift_b shift right; carry<=c; cnt<=cnt+1.
  - Edge processing bit WIDTH-1 (cnt==WIDTH-1): sum<=final partial sum, cout<=c, done<=1, busy<=0, go to DONE.
- DONE (exactly one cycle):
  - done=1.
  - start=1 accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
  - done drops to 0 on the next edge in either case.
- Latency:
  - Start sampled at edge E0; done high in the cycle after edge E_WIDTH. Result is visible WIDTH cycles after the start edge.
  - Throughput: one result per WIDTH+1 cycles when back-to-back.
- start while busy=1 is ignored: no restart, no effect on the current operation.
- a, b and cin may change freely after the start edge; they are not re-sampled.
- sum and cout change only at the completion edge (or reset); they hold through later SHIFT periods.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin. Example: all-ones + all-ones + 1 gives sum=all-ones, cout=1.
- The bit counter is $clog2(WIDTH) bits wide and never wraps: the SHIFT exit occurs at WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (out, 1): two's-complement overflow = carry into MSB XOR carry out of MSB.
  - Carry into MSB is taken from the carry flop during the last SHIFT cycle.
  - ovf is registered with sum/cout at completion, reset to 0, holds like sum.
- Undefined: port ovf and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst asynchronously (between edges) with busy=1 at cnt=4 -> busy, done, sum, cout all 0 immediately. After release, a=8'h35, b=8'h1C, cin=0 completes correctly.
- Basic, WIDTH=8: a=8'h35, b=8'h1C, cin=0, start pulse -> done exactly 8 cycles after the start edge, sum=8'h51, cout=0, busy high for exactly 8 cycles.
- Carry chain:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Stability and ignore:
  - Start op a=8'h10, b=8'h20; during SHIFT change a/b to 8'hAA and pulse start -> result sum=8'h30, cout=0.
  - sum keeps its previous value until done.
- Back-to-back: start held high through DONE with a=8'h01, b=8'h02 then a=8'h80, b=8'h80 -> done pulses 9 cycles apart; sums 8'h03 (cout=0), then 8'h00 (cout=1).
- With SERIAL_ADDER_OVF_EN:
  - a=8'h7F, b=8'h01 -> ovf=1, sum=8'h80.
  - a=8'h80, b=8'h80 -> ovf=1, cout=1.
  - a=8'hFF, b=8'h01 -> ovf=0.
